// File: rtl/bcd_seven_seg_scanner.sv
// bcd_seven_seg_scanner
// Time-multiplexed N-digit BCD-to-seven-segment driver. A pending buffer
// collects load strobes; the display buffer only takes it over at frame wrap,
// so a frame never shows a mix of old and new digits. One digit is driven per
// prescaler slot, with optional leading-zero blanking and selectable polarity.
module bcd_seven_seg_scanner #(
  parameter int DIGITS      = 4,
  parameter int PRESCALE    = 50000,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 1,
  parameter int BLANK_LZ    = 1,
  localparam int IDX_W      = $clog2(DIGITS),
  localparam int PS_W       = $clog2(PRESCALE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  // Inactive output levels; XOR-ing an active-high pattern with these gives
  // the board-level polarity.
  localparam logic [7:0]        SEG_OFF  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  // Active-high a..g glyph (a = bit 6); non-BCD codes show a dash.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110010;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1111011;
      default: g = 7'b0000001;
    endcase
    return g;
  endfunction

  logic [PS_W-1:0]     presc_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] pend_bcd_r;
  logic [DIGITS-1:0]   pend_dp_r;
  logic [4*DIGITS-1:0] disp_bcd_r;
  logic [DIGITS-1:0]   disp_dp_r;
  logic [7:0]          seg_r;
  logic [DIGITS-1:0]   dig_r;
  logic [IDX_W-1:0]    digit_idx_r;
  logic                frame_done_r;

  logic                tick_s;
  logic                wrap_s;
  logic [DIGITS-1:0]   zero_from_s;
  logic                blank_s;
  logic [3:0]          cur_code_s;
  logic                cur_dp_s;
  logic [7:0]          seg_next_s;
  logic [DIGITS-1:0]   dig_next_s;

  assign tick_s = (presc_r == PS_LAST);
  assign wrap_s = tick_s && (idx_r == IDX_LAST);

  // Prescaler: one digit slot every PRESCALE clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PS_W'(1);
    end
  end

  // Scan index advances on each slot tick and wraps after the top digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= '0;
    end else if (tick_s) begin
      idx_r <= wrap_s ? '0 : idx_r + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Pending buffer follows load; display buffer is refreshed only at frame
  // wrap, taking a coincident load directly so it is not delayed a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_bcd_r <= '0;
      pend_dp_r  <= '0;
      disp_bcd_r <= '0;
      disp_dp_r  <= '0;
    end else begin
      if (load) begin
        pend_bcd_r <= bcd_in;
        pend_dp_r  <= dp_in;
      end
      if (wrap_s) begin
        disp_bcd_r <= load ? bcd_in : pend_bcd_r;
        disp_dp_r  <= load ? dp_in  : pend_dp_r;
      end
    end
  end

  // zero_from_s[k] is set when every display digit from the top down to k is zero.
  always_comb begin : zero_scan
    logic acc;
    zero_from_s = '0;
    acc         = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc            = acc & (disp_bcd_r[4*k +: 4] == 4'd0);
      zero_from_s[k] = acc;
    end
  end

  // Select the current digit, apply blanking, polarity and the enable gate.
  always_comb begin
    cur_code_s = disp_bcd_r[{idx_r, 2'b00} +: 4];
    cur_dp_s   = disp_dp_r[idx_r];
    if ((BLANK_LZ != 0) && (idx_r != '0) && zero_from_s[idx_r]) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
    if (en) begin
      seg_next_s = {cur_dp_s, (blank_s ? 7'b0000000 : glyph(cur_code_s))} ^ SEG_OFF;
      dig_next_s = (DIGITS'(1) << idx_r) ^ DIG_OFF;
    end else begin
      seg_next_s = SEG_OFF;
      dig_next_s = DIG_OFF;
    end
  end

  // Registered outputs, one cycle behind the scan index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r        <= SEG_OFF;
      dig_r        <= DIG_OFF;
      digit_idx_r  <= '0;
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_next_s;
      dig_r        <= dig_next_s;
      digit_idx_r  <= idx_r;
      frame_done_r <= wrap_s;
    end
  end

  assign seg        = seg_r;
  assign dig        = dig_r;
  assign digit_idx  = digit_idx_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
// Bench for bcd_seven_seg_scanner: directed scenarios plus random traffic,
// all checked cycle by cycle against a time-based behavioural model.
module tb_bcd_seven_seg_scanner;

  localparam int D = 4;
  localparam int P = 4;
  localparam int FRAME = D * P;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   bcd_in;
  logic [3:0]    dp_in;
  logic          load;
  logic          en;
  logic [7:0]    seg;
  logic [3:0]    dig;
  logic [1:0]    digit_idx;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since reset plus the two buffers.
  int          n;
  logic [15:0] m_pend_bcd, m_disp_bcd;
  logic [3:0]  m_pend_dp, m_disp_dp;
  int          last_idx;

  logic [6:0] glyph_tab [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
    7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

  bcd_seven_seg_scanner #(
    .DIGITS(D), .PRESCALE(P), .SEG_ACT_LOW(0), .DIG_ACT_LOW(1), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .en(en), .seg(seg), .dig(dig), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Segment pattern for digit k: blanked when the displayed number shifted
  // down by k digits is zero (and k is not the units digit).
  function automatic logic [7:0] model_seg(input int k);
    logic [15:0] v;
    logic [6:0]  g;
    v = m_disp_bcd >> (4 * k);
    g = glyph_tab[v[3:0]];
    if (k != 0 && v == 16'd0) g = 7'b0000000;
    return {m_disp_dp[k], g};
  endfunction

  task automatic model_reset();
    n = 0;
    m_pend_bcd = 16'd0; m_disp_bcd = 16'd0;
    m_pend_dp  = 4'd0;  m_disp_dp  = 4'd0;
  endtask

  // One clock: predict, advance the model, clock, compare.
  task automatic step();
    int          idx_m;
    bit          wrap_m;
    logic [7:0]  es;
    logic [3:0]  ed;
    logic [15:0] old_bcd;
    logic [3:0]  old_dp;
    idx_m  = (n / P) % D;
    wrap_m = (n % FRAME) == FRAME - 1;
    es = en ? model_seg(idx_m) : 8'h00;
    ed = en ? ~(4'b0001 << idx_m) : 4'hF;
    old_bcd = m_pend_bcd; old_dp = m_pend_dp;
    if (load) begin m_pend_bcd = bcd_in; m_pend_dp = dp_in; end
    if (wrap_m) begin
      m_disp_bcd = load ? bcd_in : old_bcd;
      m_disp_dp  = load ? dp_in  : old_dp;
    end
    n++;
    last_idx = idx_m;
    @(posedge clk); #1;
    check_value("seg", {24'd0, seg}, {24'd0, es});
    check_value("dig", {28'd0, dig}, {28'd0, ed});
    check_value("digit_idx", {30'd0, digit_idx}, idx_m);
    check_value("frame_done", {31'd0, frame_done}, {31'd0, wrap_m});
  endtask

  task automatic load_val(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
    bcd_in = 16'($urandom); dp_in = 4'($urandom);
  endtask

  task automatic step_until_phase(input int ph);
    for (int i = 0; i < FRAME && (n % FRAME) != ph; i++) step();
    check_value("phase_reached", n % FRAME, ph);
  endtask

  // Run one full aligned frame and compare each digit with constants.
  task automatic frame_check(input string tag, input logic [31:0] exp_segs);
    logic [7:0] obs [0:3];
    step_until_phase(0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      obs[last_idx] = seg;
    end
    for (int k = 0; k < D; k++)
      check_value(tag, {24'd0, obs[k]}, {24'd0, exp_segs[8*k +: 8]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_seg"}, {24'd0, seg}, 32'h00);
    check_value({tag, "_dig"}, {28'd0, dig}, 32'hF);
    check_value({tag, "_idx"}, {30'd0, digit_idx}, 32'd0);
    check_value({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b1; bcd_in = 16'd0; dp_in = 4'd0;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // 1: blank buffers show "0" on digit 0 only.
    frame_check("t1_blank", 32'h0000_007E);
    for (int i = 0; i < 2 * FRAME; i++) step();

    // 2: mid-frame load shows up only after the next wrap.
    step_until_phase(6);
    load_val(16'h1234, 4'b0000);
    frame_check("t2_1234", 32'h306D_7933);

    // 3: leading zeros blanked, dp on digit 1.
    step_until_phase(3);
    load_val(16'h0070, 4'b0010);
    frame_check("t3_0070", 32'h0000_F27E);

    // 4: non-BCD code renders a dash.
    step_until_phase(9);
    load_val(16'h00A5, 4'b0000);
    frame_check("t4_00A5", 32'h0000_015B);

    // 5: load coincident with the wrapping tick takes effect immediately.
    step_until_phase(FRAME - 1);
    load_val(16'h9999, 4'b0000);
    frame_check("t5_9999", 32'h7B7B_7B7B);
    frame_check("t5_hold", 32'h7B7B_7B7B);

    // 6: asynchronous reset mid-frame.
    step_until_phase(7);
    #2 rst = 1'b1;
    #2 check_reset_outputs("t6_async");
    @(posedge clk); #1;
    check_reset_outputs("t6_held");
    rst = 1'b0;
    model_reset();
    frame_check("t6_restart", 32'h0000_007E);

    // 7: display dark while scanning continues.
    load_val(16'h4321, 4'b1111);
    for (int i = 0; i < FRAME; i++) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    en = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) begin
        logic [15:0] v;
        v = 16'($urandom) >> (4 * $urandom_range(0, 4));
        load_val(v, 4'($urandom));
      end else begin
        bcd_in = 16'($urandom); dp_in = 4'($urandom);
        step();
      end
    end
    en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
